// File: rtl/rf_wport_sched_pkg.sv
// rf_wport_sched_pkg: shared register-address and write-request types for the write-port scheduler
package rf_wport_sched_pkg;
  typedef logic [3:0] reg_addr_t;
  localparam reg_addr_t R_PC = 4'd15;
  typedef struct packed {
    reg_addr_t   wa;
    logic [31:0] wd;
  } wr_req_t;
endpackage

// File: rtl/rf_wport_sched_if.sv
// rf_wport_sched_if: WB, MC, issue-stage and regfile-port signals around the write-port scheduler
interface rf_wport_sched_if;
  import rf_wport_sched_pkg::*;
  logic        wb_we;
  reg_addr_t   wb_wa;
  logic [31:0] wb_wd;
  logic        mc_valid;
  logic        mc_ready;
  reg_addr_t   mc_wa;
  logic [31:0] mc_wd;
  logic        iss_valid;
  logic        iss_we;
  logic        iss_mc;
  reg_addr_t   iss_rd;
  reg_addr_t   iss_ra1;
  reg_addr_t   iss_ra2;
  reg_addr_t   iss_ra3;
  logic        hazard;
  logic        stall_req;
  logic        rf_we;
  reg_addr_t   rf_wa;
  logic [31:0] rf_wd;
  logic        err_r15;
  modport slave (
    input  wb_we, wb_wa, wb_wd, mc_valid, mc_wa, mc_wd,
           iss_valid, iss_we, iss_mc, iss_rd, iss_ra1, iss_ra2, iss_ra3,
    output mc_ready, hazard, stall_req, rf_we, rf_wa, rf_wd, err_r15
  );
  modport master (
    output wb_we, wb_wa, wb_wd, mc_valid, mc_wa, mc_wd,
           iss_valid, iss_we, iss_mc, iss_rd, iss_ra1, iss_ra2, iss_ra3,
    input  mc_ready, hazard, stall_req, rf_we, rf_wa, rf_wd, err_r15
  );
endinterface

// File: rtl/rf_wport_sched_wq_fifo.sv
// rf_wport_sched_wq_fifo: small FIFO of pending MC write requests
module rf_wport_sched_wq_fifo
  import rf_wport_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push_i,
  input  logic    pop_i,
  input  wr_req_t din_i,
  output wr_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  wr_req_t     mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  // extra pointer bit distinguishes full from empty when the indices match
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];
  always_comb begin
    wr_d = push_i ? wr_q + ONE : wr_q;
    rd_d = pop_i ? rd_q + ONE : rd_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/rf_wport_sched.sv
// rf_wport_sched: arbitrates the regfile write port between WB and queued MC results,
// tracks in-flight MC destinations and raises issue hazards and WB stall requests
module rf_wport_sched
  import rf_wport_sched_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             reset_n,
  rf_wport_sched_if.slave bus
);
  localparam int AGW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGW-1:0] LIM = AGW'(STARVE_LIMIT);
  localparam logic [AGW-1:0] ONE = 1;
  wr_req_t        head;
  logic           full, empty, push, pop, wb_ok, hd_ok, set;
  logic [15:0]    bv;
  logic [14:0]    busy_q, busy_d;
  logic [AGW-1:0] age_q, age_d;
  logic           stall_q, err_q, err_d;
  rf_wport_sched_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ('{wa: bus.mc_wa, wd: bus.mc_wd}),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  // R15 slot in bv is hard zero so lookups of R15 never report busy
  always_comb begin
    push   = bus.mc_valid && !full;
    wb_ok  = bus.wb_we && bus.wb_wa != R_PC;
    pop    = !empty && !wb_ok;
    hd_ok  = pop && head.wa != R_PC;
    bv     = {1'b0, busy_q};
    bus.hazard = bus.iss_valid && (bv[bus.iss_ra1] || bv[bus.iss_ra2] || bv[bus.iss_ra3] ||
                                   (bus.iss_we && bv[bus.iss_rd]));
    set    = bus.iss_valid && !bus.hazard && bus.iss_we && bus.iss_mc && bus.iss_rd != R_PC;
    busy_d = (busy_q & ~(15'(hd_ok) << head.wa)) | (15'(set) << bus.iss_rd);
    age_d  = (empty || pop) ? '0 : (age_q >= LIM ? LIM : age_q + ONE);
    err_d  = err_q || (bus.wb_we && bus.wb_wa == R_PC) || (pop && head.wa == R_PC);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      busy_q  <= '0;
      age_q   <= '0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      age_q   <= age_d;
      stall_q <= age_d >= LIM;
      err_q   <= err_d;
    end
  assign bus.mc_ready  = !full;
  assign bus.stall_req = stall_q;
  assign bus.err_r15   = err_q;
  assign bus.rf_we     = reset_n && (wb_ok || hd_ok);
  assign bus.rf_wa     = wb_ok ? bus.wb_wa : head.wa;
  assign bus.rf_wd     = wb_ok ? bus.wb_wd : head.wd;
endmodule

// File: tb/tb_rf_wport_sched.sv
// tb_rf_wport_sched: directed checks of write arbitration, scoreboard hazards, starvation and reset
module tb_rf_wport_sched;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  rf_wport_sched_if bus();
  rf_wport_sched #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic idle();
    bus.wb_we = 0; bus.wb_wa = 0; bus.wb_wd = 0;
    bus.mc_valid = 0; bus.mc_wa = 0; bus.mc_wd = 0;
    bus.iss_valid = 0; bus.iss_we = 0; bus.iss_mc = 0;
    bus.iss_rd = 0; bus.iss_ra1 = 0; bus.iss_ra2 = 0; bus.iss_ra3 = 0;
  endtask
  task automatic nx();
    @(negedge clk);
    idle();
  endtask
  task automatic wb(input logic [3:0] a, input logic [31:0] d);
    bus.wb_we = 1; bus.wb_wa = a; bus.wb_wd = d;
  endtask
  task automatic mc(input logic [3:0] a, input logic [31:0] d);
    bus.mc_valid = 1; bus.mc_wa = a; bus.mc_wd = d;
  endtask
  task automatic iss(input logic we, input logic m, input logic [3:0] rd, input logic [3:0] ra1);
    bus.iss_valid = 1; bus.iss_we = we; bus.iss_mc = m; bus.iss_rd = rd; bus.iss_ra1 = ra1;
  endtask
  initial begin
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rf_we", 32'(bus.rf_we), 0);
    chk("rst_mc_ready", 32'(bus.mc_ready), 1);
    chk("rst_hazard", 32'(bus.hazard), 0);
    chk("rst_stall", 32'(bus.stall_req), 0);
    chk("rst_err", 32'(bus.err_r15), 0);
    nx(); reset_n = 1;
    // WB only
    nx(); wb(3, 32'hDEADBEEF); #1;
    chk("wb_we", 32'(bus.rf_we), 1);
    chk("wb_wa", 32'(bus.rf_wa), 3);
    chk("wb_wd", bus.rf_wd, 32'hDEADBEEF);
    chk("wb_hazard", 32'(bus.hazard), 0);
    // MC drain and RAW hazard
    nx(); iss(1, 1, 5, 0); #1;
    chk("raw_issue_hz", 32'(bus.hazard), 0);
    nx(); iss(1, 0, 6, 5); mc(5, 32'h1234); #1;
    chk("raw_hz", 32'(bus.hazard), 1);
    chk("raw_ready", 32'(bus.mc_ready), 1);
    chk("raw_nobypass_we", 32'(bus.rf_we), 0);
    nx(); iss(1, 0, 6, 5); #1;
    chk("raw_drain_we", 32'(bus.rf_we), 1);
    chk("raw_drain_wa", 32'(bus.rf_wa), 5);
    chk("raw_drain_wd", bus.rf_wd, 32'h1234);
    chk("raw_pop_hz", 32'(bus.hazard), 1);
    nx(); iss(1, 0, 6, 5); #1;
    chk("raw_clear_hz", 32'(bus.hazard), 0);
    chk("raw_idle_we", 32'(bus.rf_we), 0);
    // contention and starvation
    nx(); wb(1, 1); mc(8, 32'hA); #1;
    chk("ct_ready0", 32'(bus.mc_ready), 1);
    chk("ct_wb_wa", 32'(bus.rf_wa), 1);
    nx(); wb(1, 1); mc(9, 32'hB); #1;
    chk("ct_ready1", 32'(bus.mc_ready), 1);
    nx(); wb(1, 1); mc(10, 32'hC); #1;
    chk("ct_full", 32'(bus.mc_ready), 0);
    chk("ct_stall_a2", 32'(bus.stall_req), 0);
    nx(); wb(1, 1); #1;
    chk("ct_stall_a3", 32'(bus.stall_req), 0);
    nx(); wb(1, 1); #1;
    chk("ct_stall_a4", 32'(bus.stall_req), 0);
    nx(); wb(1, 2); #1;
    chk("ct_stall_on", 32'(bus.stall_req), 1);
    chk("ct_viol_wa", 32'(bus.rf_wa), 1);
    chk("ct_viol_wd", bus.rf_wd, 2);
    nx(); #1;
    chk("ct_hold_stall", 32'(bus.stall_req), 1);
    chk("ct_head_we", 32'(bus.rf_we), 1);
    chk("ct_head_wa", 32'(bus.rf_wa), 8);
    chk("ct_head_wd", bus.rf_wd, 32'hA);
    nx(); #1;
    chk("ct_stall_off", 32'(bus.stall_req), 0);
    chk("ct_2nd_wa", 32'(bus.rf_wa), 9);
    chk("ct_2nd_wd", bus.rf_wd, 32'hB);
    chk("ct_ready_back", 32'(bus.mc_ready), 1);
    nx(); #1;
    chk("ct_empty_we", 32'(bus.rf_we), 0);
    // R15 handling
    nx(); wb(15, 32'h55); mc(15, 32'h66); #1;
    chk("r15_wb_we", 32'(bus.rf_we), 0);
    chk("r15_err_pre", 32'(bus.err_r15), 0);
    nx(); iss(0, 0, 0, 5); #1;
    chk("r15_head_we", 32'(bus.rf_we), 0);
    chk("r15_err", 32'(bus.err_r15), 1);
    chk("r15_busy", 32'(bus.hazard), 0);
    nx(); #1;
    chk("r15_err_sticky", 32'(bus.err_r15), 1);
    chk("r15_popped", 32'(bus.mc_ready), 1);
    // WAW
    nx(); iss(1, 1, 7, 0); #1;
    chk("waw_issue_hz", 32'(bus.hazard), 0);
    nx(); iss(1, 0, 7, 0); mc(7, 32'h77); #1;
    chk("waw_hz", 32'(bus.hazard), 1);
    nx(); iss(1, 0, 7, 0); #1;
    chk("waw_pop_hz", 32'(bus.hazard), 1);
    chk("waw_wa", 32'(bus.rf_wa), 7);
    chk("waw_we", 32'(bus.rf_we), 1);
    nx(); iss(1, 0, 7, 0); #1;
    chk("waw_clear_hz", 32'(bus.hazard), 0);
    // reset mid-operation
    nx(); iss(1, 1, 5, 0); wb(1, 1); mc(12, 32'hC0); #1;
    chk("mr_issue_hz", 32'(bus.hazard), 0);
    nx(); wb(1, 1); mc(13, 32'hD0); #1;
    nx(); wb(1, 1); iss(0, 0, 0, 5); #1;
    chk("mr_full", 32'(bus.mc_ready), 0);
    chk("mr_hz", 32'(bus.hazard), 1);
    bus.wb_we = 0;
    #1;
    chk("mr_pre_we", 32'(bus.rf_we), 1);
    #1 reset_n = 0;
    #1;
    chk("mr_rf_we", 32'(bus.rf_we), 0);
    chk("mr_ready", 32'(bus.mc_ready), 1);
    chk("mr_hazard", 32'(bus.hazard), 0);
    chk("mr_stall", 32'(bus.stall_req), 0);
    nx(); reset_n = 1; iss(0, 0, 0, 5); #1;
    chk("mr_post_we", 32'(bus.rf_we), 0);
    chk("mr_post_hz", 32'(bus.hazard), 0);
    nx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
